// File: rtl/lane_unstriping_fifo.sv
// Two-lane receive merger: each byte lane is buffered in its own FIFO and the
// lanes are popped alternately (0,1,0,1,...) into a registered valid/ready output.
module lane_unstriping_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in_0,
  input  logic              valid_in_0,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic              valid_in_1,
  input  logic              ready_out,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              fifo_full_0,
  output logic              fifo_full_1,
  output logic              fifo_empty_0,
  output logic              fifo_empty_1,
  output logic              lane_sel,
  output logic              overflow_err
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic {
    WAIT0 = 1'b0,
    WAIT1 = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [2][DEPTH];
  logic [AW-1:0]     wr_ptr [2];
  logic [AW-1:0]     rd_ptr [2];
  logic [AW:0]       count  [2];

  logic [DATA_W-1:0] lane_data [2];
  logic [1:0]        lane_valid;
  logic [1:0]        full, empty, pop, push, drop;
  logic [DATA_W-1:0] head_data;
  logic              free;

  always_comb begin
    lane_data[0] = data_in_0;
    lane_data[1] = data_in_1;
    lane_valid   = {valid_in_1, valid_in_0};
    for (int i = 0; i < 2; i++) begin
      full[i]  = (count[i] == FULL_CNT);
      empty[i] = (count[i] == '0);
    end
  end

  assign free = !valid_out || ready_out;

  // Merger: the selected lane is the only one ever popped, so the lanes never reorder.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nxt = state;
    pop       = '0;
    case (state)
      WAIT0: if (free && !empty[0]) begin
        pop[0]    = 1'b1;
        state_nxt = WAIT1;
      end
      WAIT1: if (free && !empty[1]) begin
        pop[1]    = 1'b1;
        state_nxt = WAIT0;
      end
    endcase
  end

  // A full lane still accepts a byte when its head leaves in the same cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      push[i] = lane_valid[i] && (!full[i] || pop[i]);
      drop[i] = lane_valid[i] && full[i] && !pop[i];
    end
    head_data = (state == WAIT1) ? mem[1][rd_ptr[1]] : mem[0][rd_ptr[0]];
  end

  // NOTE: storage has no reset; the cleared pointers and counts make stale contents unreachable.
  always_ff @(posedge clk_2f) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= lane_data[i];
    end
  end

  // NOTE: registered state is updated only with non-blocking assignments.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CNT_ONE;
          2'b01:   count[i] <= count[i] - CNT_ONE;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      state        <= WAIT0;
      data_out     <= '0;
      valid_out    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (free) begin
        if (|pop) begin
          data_out  <= head_data;
          valid_out <= 1'b1;
        end else begin
          valid_out <= 1'b0;
        end
      end
      if (|drop) overflow_err <= 1'b1;
    end
  end

  assign lane_sel     = (state == WAIT1);
  assign fifo_full_0  = full[0];
  assign fifo_full_1  = full[1];
  assign fifo_empty_0 = empty[0];
  assign fifo_empty_1 = empty[1];

endmodule
